// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state enum, default divider, data width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

  localparam int UART_DIV_DEFAULT = 434;
  localparam int UART_DATA_W      = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial line plus falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  // All three flops reset high so an idle line never produces a false edge.
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART byte receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Good bytes appear on mosi with a one-cycle rok; framing/parity faults pulse their own strobe.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DIV = UART_DIV_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] mosi,
  output logic                   rok,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   busy,
  output uart_rx_state_t         dbg_state
);

  localparam logic [15:0] FULL = 16'(DIV - 1);
  localparam logic [15:0] HALF = 16'(DIV / 2 - 1);

  logic rx_s, rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  uart_rx_state_t         state_q;
  logic [15:0]            dcnt_q;
  logic [3:0]             bcnt_q;
  logic [UART_DATA_W-1:0] sh_q, mosi_q;
  logic                   rok_q, ferr_q, perr_q, pbad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      mosi_q  <= '0;
      rok_q   <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
    end else begin
      rok_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      dcnt_q <= dcnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          dcnt_q <= '0;
          pbad_q <= 1'b0;
          if (rx_fall) state_q <= START;
        end
        // Mid-start-bit sample: a line already back high was only a glitch.
        START: begin
          if (dcnt_q == HALF) begin
            dcnt_q  <= '0;
            bcnt_q  <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (dcnt_q == FULL) begin
            dcnt_q <= '0;
            sh_q   <= {rx_s, sh_q[UART_DATA_W-1:1]};
            bcnt_q <= bcnt_q + 4'd1;
            if (bcnt_q == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (dcnt_q == FULL) begin
            dcnt_q  <= '0;
            pbad_q  <= (rx_s != ^sh_q);
            state_q <= STOP;
          end
        end
`endif
        // Leaving at the stop mid-bit lets a back-to-back start edge be caught.
        STOP: begin
          if (dcnt_q == FULL) begin
            dcnt_q <= '0;
            if (!rx_s) begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end else begin
              if (pbad_q) begin
                perr_q <= 1'b1;
              end else begin
                rok_q  <= 1'b1;
                mosi_q <= sh_q;
              end
              state_q <= IDLE;
            end
          end
        end
        BREAK: begin
          dcnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mosi       = mosi_q;
  assign rok        = rok_q;
  assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule
